// File: rtl/aes_block_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aes_block_serializer
// Function : double-slotted 128-bit block to DATA_W-bit word serializer, MSB first
// Revision : 1.0
//------------------------------------------------------------------------------
module aes_block_serializer #(
  parameter int BLOCK_W = 128,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_valid,
  output logic               blk_ready,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_count
);

  localparam int c_NWORDS = BLOCK_W / DATA_W;
  localparam int c_IDX_W  = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NWORDS - 1);

  logic               r_act_vld;
  logic [BLOCK_W-1:0] r_shift;
  logic [c_IDX_W-1:0] r_word_idx;
  logic               r_pend_vld;
  logic [BLOCK_W-1:0] r_pend_data;
  logic [CNT_W-1:0]   r_blk_count;

  logic w_in_fire;
  logic w_out_fire;
  logic w_out_end;
  logic w_act_free;

  assign blk_ready  = !r_pend_vld;
  assign tx_valid   = r_act_vld;
  assign tx_last    = r_act_vld & (r_word_idx == c_LAST_IDX);
  assign tx_data    = r_shift[BLOCK_W-1 -: DATA_W];
  assign busy       = r_act_vld | r_pend_vld;
  assign blk_count  = r_blk_count;

  assign w_in_fire  = blk_valid & blk_ready;
  assign w_out_fire = tx_valid & tx_ready;
  assign w_out_end  = w_out_fire & tx_last;
  assign w_act_free = !r_act_vld | w_out_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_vld   <= 1'b0;
      r_shift     <= '0;
      r_word_idx  <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_blk_count <= '0;
    end else begin
      if (w_out_fire) begin
        r_shift    <= r_shift << DATA_W;
        r_word_idx <= r_word_idx + 1'b1;
      end
      if (w_out_end) begin
        r_word_idx  <= '0;
        r_blk_count <= r_blk_count + 1'b1;
      end
      // Loads below override the shift so a new block starts the cycle after the old one ends.
      if (w_act_free) begin
        if (r_pend_vld) begin
          r_shift    <= r_pend_data;
          r_act_vld  <= 1'b1;
          r_pend_vld <= w_in_fire;
          if (w_in_fire) r_pend_data <= blk_data;
        end else if (w_in_fire) begin
          r_shift   <= blk_data;
          r_act_vld <= 1'b1;
        end else begin
          r_act_vld <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_pend_data <= blk_data;
        r_pend_vld  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_block_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_aes_block_serializer
// Function : directed self-checking bench for aes_block_serializer
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_aes_block_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;
  logic         busy;
  logic [15:0]  blk_count;

  logic [127:0] blk_data2;
  logic         blk_valid2;
  logic         blk_ready2;
  logic [7:0]   tx_data2;
  logic         tx_valid2;
  logic         tx_last2;
  logic         busy2;
  logic [1:0]   blk_count2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_block_serializer #(.BLOCK_W(128), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .busy(busy), .blk_count(blk_count)
  );

  aes_block_serializer #(.BLOCK_W(128), .DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .blk_data(blk_data2), .blk_valid(blk_valid2),
    .blk_ready(blk_ready2), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(1'b1),
    .tx_last(tx_last2), .busy(busy2), .blk_count(blk_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Word i of block k in the back-to-back test is {k+1, i}.
  function automatic logic [127:0] mk_blk(input int k);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = {4'(k + 1), 4'(i)};
    return b;
  endfunction

  initial begin
    logic [127:0] blk;
    int           k;
    int           nw;
    logic         fire;

    reset = 1'b1; blk_data = '0; blk_valid = 1'b0; tx_ready = 1'b1;
    blk_data2 = '0; blk_valid2 = 1'b0;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", blk_count, 0);
    chk("rst_ready", blk_ready, 1);
    step();
    reset = 1'b0;

    // 1: single block, words 00,11,...,FF
    blk = 128'h00112233445566778899AABBCCDDEEFF;
    blk_data = blk; blk_valid = 1'b1;
    chk("t1_ready", blk_ready, 1);
    step();
    blk_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t1_valid", tx_valid, 1);
      chk("t1_data", tx_data, 32'(i * 8'h11));
      chk("t1_last", tx_last, (i == 15) ? 1 : 0);
      step();
    end
    chk("t1_idle_valid", tx_valid, 0);
    chk("t1_count", blk_count, 1);
    chk("t1_busy", busy, 0);

    // 2 + 4: three blocks back-to-back, pending full during last-word transfer
    do_reset();
    k = 0;
    blk_data = mk_blk(0); blk_valid = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      if (c >= 1) begin
        chk("t2_valid", tx_valid, 1);
        chk("t2_data", tx_data, {24'h0, 4'((c - 1) / 16 + 1), 4'((c - 1) % 16)});
        chk("t2_last", tx_last, ((c - 1) % 16 == 15) ? 1 : 0);
      end
      if (c == 2 || c == 16 || c == 32) chk("t2_ready_full", blk_ready, 0);
      if (c == 17) chk("t2_ready_back", blk_ready, 1);
      fire = blk_valid & blk_ready;
      step();
      if (fire) begin
        k++;
        if (k == 3) blk_valid = 1'b0;
        else blk_data = mk_blk(k);
      end
    end
    chk("t2_idle_valid", tx_valid, 0);
    chk("t2_count", blk_count, 3);
    chk("t2_busy", busy, 0);

    // 3: stall after word 6
    do_reset();
    blk_data = {16{8'hA5}}; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    repeat (7) step();
    tx_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk("t3_stall_valid", tx_valid, 1);
      chk("t3_stall_data", tx_data, 32'hA5);
      chk("t3_stall_last", tx_last, 0);
      step();
    end
    tx_ready = 1'b1;
    nw = 0;
    for (int w = 0; w < 20 && tx_valid; w++) begin
      chk("t3_data", tx_data, 32'hA5);
      nw++;
      if (tx_last) begin
        step();
        break;
      end
      step();
    end
    chk("t3_remaining_words", nw, 9);
    chk("t3_idle_valid", tx_valid, 0);
    chk("t3_count", blk_count, 1);

    // 5: reset mid-block
    do_reset();
    blk = 128'h00112233445566778899AABBCCDDEEFF;
    blk_data = blk; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    repeat (8) step();
    chk("t5_pre_data", tx_data, 32'h88);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", tx_valid, 0);
    chk("t5_rst_last", tx_last, 0);
    chk("t5_rst_data", tx_data, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", blk_ready, 1);
    chk("t5_rst_count", blk_count, 0);
    step();
    reset = 1'b0;
    blk_data = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk("t5_word0", tx_data, 32'hF0);
    step();
    chk("t5_word1", tx_data, 32'hE1);
    repeat (15) step();
    chk("t5_count", blk_count, 1);
    chk("t5_busy", busy, 0);

    // 6: 2-bit counter wraps
    do_reset();
    for (int b = 0; b < 5; b++) begin
      blk_data2 = mk_blk(b); blk_valid2 = 1'b1;
      step();
      blk_valid2 = 1'b0;
      repeat (16) step();
      chk("t6_count", blk_count2, (b + 1) % 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
